// File: rtl/synth_cfg_ctrl_pkg.sv
// Shared constants, opcodes and FSM state type for the synth voice configuration controller.
package synth_pkg;

    localparam int CFG_W = 60;
    localparam int PAD_W = 64;

    localparam logic [7:0] OP_WRITE_CFG = 8'h01;
    localparam logic [7:0] OP_GATE_ON   = 8'h02;
    localparam logic [7:0] OP_GATE_OFF  = 8'h03;

    localparam int AI_LSB  = 0;
    localparam int DI_LSB  = 8;
    localparam int S_LSB   = 16;
    localparam int RI_LSB  = 24;
    localparam int OSC_LSB = 32;
    localparam int FA_LSB  = 44;
    localparam int FB_LSB  = 52;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OPCODE   = 3'd1,
        PAYLOAD  = 3'd2,
        WAIT_END = 3'd3,
        ERROR    = 3'd4
    } state_t;

endpackage

// File: rtl/synth_cfg_ctrl_if.sv
// SPI pin bundle between the host-side driver and the configuration controller.
interface synth_cfg_ctrl_if;
    logic sclk;
    logic mosi;
    logic nss;

    modport master (output sclk, output mosi, output nss);
    modport slave  (input  sclk, input  mosi, input  nss);
endinterface

// File: rtl/synth_cfg_ctrl_spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain and produces registered edge strobes.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic arstn,
    input  logic sclk_i,
    input  logic mosi_i,
    input  logic nss_i,
    output logic sclk_rise_o,
    output logic nss_fall_o,
    output logic nss_rise_o,
    output logic mosi_s_o
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] nss_sync_q;
    logic                   sclk_prev_q;
    logic                   nss_prev_q;

    // Synchroniser chains, edge history and registered strobes; idle bus is sclk low, nss high.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            nss_sync_q  <= '1;
            sclk_prev_q <= 1'b0;
            nss_prev_q  <= 1'b1;
            sclk_rise_o <= 1'b0;
            nss_fall_o  <= 1'b0;
            nss_rise_o  <= 1'b0;
            mosi_s_o    <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], nss_i};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            nss_prev_q  <= nss_sync_q[SYNC_STAGES-1];
            sclk_rise_o <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
            nss_fall_o  <= ~nss_sync_q[SYNC_STAGES-1] & nss_prev_q;
            nss_rise_o  <= nss_sync_q[SYNC_STAGES-1] & ~nss_prev_q;
            mosi_s_o    <= mosi_sync_q[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/synth_cfg_ctrl.sv
// Framed SPI slave: decodes an opcode byte, stages voice config in a shadow and commits at frame end.
module synth_cfg_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int CFG_W       = synth_pkg::CFG_W,
    parameter int PAD_W       = synth_pkg::PAD_W
) (
    input  logic             clk,
    input  logic             arstn,
    synth_cfg_ctrl_if.slave  spi,
    output logic [CFG_W-1:0] cfg_o,
    output logic             cfg_upd_o,
    output logic             trig_o,
    output logic             mute_o,
    output logic             frame_err_o
);
    import synth_pkg::*;

    logic sclk_rise_s, nss_fall_s, nss_rise_s, mosi_s;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (clk),
        .arstn       (arstn),
        .sclk_i      (spi.sclk),
        .mosi_i      (spi.mosi),
        .nss_i       (spi.nss),
        .sclk_rise_o (sclk_rise_s),
        .nss_fall_o  (nss_fall_s),
        .nss_rise_o  (nss_rise_s),
        .mosi_s_o    (mosi_s)
    );

    state_t           state_q, state_d;
    logic [7:0]       op_q, op_d;
    logic [6:0]       cnt_q, cnt_d;
    // Only the low CFG_W payload bits survive; the pad bits shift out of the top.
    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic             upd_q, upd_d;
    logic             trig_q, trig_d;
    logic             mute_q, mute_d;
    logic             err_q, err_d;

    // State, shadow and output registers.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= IDLE;
            op_q     <= 8'h00;
            cnt_q    <= 7'd0;
            shadow_q <= '0;
            cfg_q    <= '0;
            upd_q    <= 1'b0;
            trig_q   <= 1'b0;
            mute_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            cfg_q    <= cfg_d;
            upd_q    <= upd_d;
            trig_q   <= trig_d;
            mute_q   <= mute_d;
            err_q    <= err_d;
        end
    end

    // Next state; frame end outranks an abort, which outranks a same-cycle sclk edge.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        cfg_d    = cfg_q;
        upd_d    = 1'b0;
        trig_d   = trig_q;
        mute_d   = mute_q;
        err_d    = 1'b0;
        if (state_q == IDLE) begin
            if (nss_fall_s) begin
                state_d = OPCODE;
                cnt_d   = 7'd0;
                op_d    = 8'h00;
            end else begin
                state_d = IDLE;
            end
        end else if (nss_rise_s) begin
            state_d = IDLE;
            cnt_d   = 7'd0;
            if (state_q == WAIT_END) begin
                case (op_q)
                    OP_WRITE_CFG: begin
                        cfg_d  = shadow_q;
                        upd_d  = 1'b1;
                        mute_d = 1'b0;
                    end
                    OP_GATE_ON:  trig_d = 1'b1;
                    OP_GATE_OFF: trig_d = 1'b0;
                    default: begin
                        err_d  = 1'b1;
                        mute_d = 1'b0;
                    end
                endcase
            end else begin
                err_d  = 1'b1;
                mute_d = 1'b0;
            end
        end else if (nss_fall_s) begin
            err_d   = 1'b1;
            mute_d  = 1'b0;
            state_d = OPCODE;
            cnt_d   = 7'd0;
            op_d    = 8'h00;
        end else if (sclk_rise_s) begin
            case (state_q)
                OPCODE: begin
                    op_d = {op_q[6:0], mosi_s};
                    if (cnt_q == 7'd7) begin
                        cnt_d = 7'd0;
                        case (op_d)
                            OP_WRITE_CFG: begin
                                state_d = PAYLOAD;
                                mute_d  = 1'b1;
                            end
                            OP_GATE_ON:  state_d = WAIT_END;
                            OP_GATE_OFF: state_d = WAIT_END;
                            default:     state_d = ERROR;
                        endcase
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                PAYLOAD: begin
                    shadow_d = {shadow_q[CFG_W-2:0], mosi_s};
                    if (cnt_q == 7'(PAD_W - 1)) begin
                        state_d = WAIT_END;
                        cnt_d   = 7'd0;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                WAIT_END: state_d = ERROR;
                default:  state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign cfg_o       = cfg_q;
    assign cfg_upd_o   = upd_q;
    assign trig_o      = trig_q;
    assign mute_o      = mute_q;
    assign frame_err_o = err_q;

endmodule
